// File: rtl/pipeline_hazard.sv
// -----------------------------------------------------------------------------
// pipeline_hazard
//
// Hazard detection and forwarding control for a 5-stage MIPS pipeline
// (IF, ID, EX, MEM, WB). The block sits beside the ID stage.
//
// Forwarding
//   ForwardA/ForwardB : EX operand selects.
//                       00 = register file, 10 = MEM ALU result, 01 = WB data.
//   ForwardC/ForwardD : the ID-stage branch comparator takes the MEM ALU result.
//
// Pipeline control
//   PC_Write, IFID_Write : PC and IF/ID enables. They drop to 0 on stall cycles.
//   IDEX_flush           : inserts a bubble into ID/EX on stall cycles.
//   IFID_flush           : squashes the fetched instruction when a taken
//                          branch or a jump resolves in ID.
//
// Performance and debug
//   stall_cnt : count of stall cycles (wraps).
//   flush_cnt : count of IF/ID flush cycles (wraps).
//   dbg_state : current FSM state. 0 = RUN, 1 = STALL_B.
//
// Reset: reset is asynchronous and active-low. While reset is low, every
// hazard and forward output is held at its idle value.
// -----------------------------------------------------------------------------
module pipeline_hazard #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UseRt,
    input  logic             ID_Branch,
    input  logic             ID_JumpReg,
    input  logic             IDcontrol_Branch,
    input  logic             IDcontrol_Jump,
    input  logic [4:0]       EX_rs,
    input  logic [4:0]       EX_rt,
    input  logic [4:0]       EX_WrReg,
    input  logic             EX_RegWr,
    input  logic             EX_MemRd,
    input  logic [4:0]       MEM_WrReg,
    input  logic             MEM_RegWr,
    input  logic             MEM_MemRd,
    input  logic [4:0]       WB_WrReg,
    input  logic             WB_RegWr,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             ForwardC,
    output logic             ForwardD,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             dbg_state
);

    typedef enum logic {
        RUN     = 1'b0,
        STALL_B = 1'b1
    } state_t;

    state_t state, state_nxt;

    // A register match. $0 is hard-wired to zero, so it never creates a dependence.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    logic id_redirect;   // ID resolves its target and needs operands now
    logic dep_ex;        // ID reads the EX destination
    logic dep_mem;       // ID reads the MEM destination
    logic hz_lu;
    logic hz_br_ex;
    logic hz_br_ld_ex;
    logic hz_br_ld_mem;
    logic stall;

    always_comb begin
        id_redirect  = ID_Branch | ID_JumpReg;
        dep_ex       = reg_hit(EX_WrReg, ID_rs)  | (ID_UseRt & reg_hit(EX_WrReg, ID_rt));
        dep_mem      = reg_hit(MEM_WrReg, ID_rs) | (ID_UseRt & reg_hit(MEM_WrReg, ID_rt));
        hz_lu        = EX_MemRd & dep_ex;
        hz_br_ex     = id_redirect & EX_RegWr & ~EX_MemRd & dep_ex;
        hz_br_ld_ex  = id_redirect & hz_lu;
        hz_br_ld_mem = id_redirect & MEM_MemRd & dep_mem;
    end

    // Next-state logic and all outputs. A load feeding a branch in ID needs two
    // bubbles: one until the load reaches MEM, and one more until its data
    // reaches WB, where write-before-read in the register file covers ID.
    // STALL_B adds the second bubble without re-checking the inputs.
    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        ForwardA   = 2'b00;
        ForwardB   = 2'b00;
        ForwardC   = 1'b0;
        ForwardD   = 1'b0;
        PC_Write   = 1'b1;
        IFID_Write = 1'b1;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;

        if (reset) begin
            // MEM is younger than WB, so MEM wins.
            if (MEM_RegWr && reg_hit(MEM_WrReg, EX_rs))
                ForwardA = 2'b10;
            else if (WB_RegWr && reg_hit(WB_WrReg, EX_rs))
                ForwardA = 2'b01;

            if (MEM_RegWr && reg_hit(MEM_WrReg, EX_rt))
                ForwardB = 2'b10;
            else if (WB_RegWr && reg_hit(WB_WrReg, EX_rt))
                ForwardB = 2'b01;

            // A load in MEM has no data yet, so it is excluded here. That case
            // is covered by hz_br_ld_mem.
            ForwardC = id_redirect & MEM_RegWr & ~MEM_MemRd & reg_hit(MEM_WrReg, ID_rs);
            ForwardD = id_redirect & MEM_RegWr & ~MEM_MemRd & ID_UseRt
                       & reg_hit(MEM_WrReg, ID_rt);

            unique case (state)
                RUN: begin
                    if (hz_br_ld_ex) begin
                        stall     = 1'b1;
                        state_nxt = STALL_B;
                    end else if (hz_lu || hz_br_ex || hz_br_ld_mem) begin
                        stall     = 1'b1;
                    end
                end
                STALL_B: begin
                    stall     = 1'b1;
                    state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase

            // Stall wins over flush. A branch is resolved only after its
            // operands are valid.
            if (stall) begin
                PC_Write   = 1'b0;
                IFID_Write = 1'b0;
                IDEX_flush = 1'b1;
            end else begin
                IFID_flush = (ID_Branch & IDcontrol_Branch) | IDcontrol_Jump;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (stall)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (IFID_flush)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign dbg_state = (state == STALL_B);

endmodule

// File: tb/tb_pipeline_hazard.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard
//
// Self-checking bench for pipeline_hazard. A behavioural model tracks the
// number of forced stall cycles still owed and the two event counters.
// Each cycle the model predicts every DUT output, and directed cases from
// the test plan add fixed expected values on top.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       ID_rs, ID_rt, EX_rs, EX_rt, EX_WrReg, MEM_WrReg, WB_WrReg;
    logic             ID_UseRt, ID_Branch, ID_JumpReg, IDcontrol_Branch, IDcontrol_Jump;
    logic             EX_RegWr, EX_MemRd, MEM_RegWr, MEM_MemRd, WB_RegWr;
    logic [1:0]       ForwardA, ForwardB;
    logic             ForwardC, ForwardD, PC_Write, IFID_Write, IFID_flush, IDEX_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    int m_extra  = 0;   // forced stall cycles still owed after a load->branch hazard
    int m_stalls = 0;
    int m_flushes = 0;

    pipeline_hazard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRt(ID_UseRt), .ID_Branch(ID_Branch),
        .ID_JumpReg(ID_JumpReg), .IDcontrol_Branch(IDcontrol_Branch),
        .IDcontrol_Jump(IDcontrol_Jump),
        .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_WrReg(EX_WrReg), .EX_RegWr(EX_RegWr),
        .EX_MemRd(EX_MemRd),
        .MEM_WrReg(MEM_WrReg), .MEM_RegWr(MEM_RegWr), .MEM_MemRd(MEM_MemRd),
        .WB_WrReg(WB_WrReg), .WB_RegWr(WB_RegWr),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .ForwardC(ForwardC), .ForwardD(ForwardD),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_flush(IFID_flush),
        .IDEX_flush(IDEX_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .dbg_state(dbg_state)
    );

    // Clock and cycle watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model helpers
    function automatic int fwd_ex(input logic [4:0] src);
        if (MEM_RegWr && MEM_WrReg != 0 && MEM_WrReg == src) return 2;
        if (WB_RegWr && WB_WrReg != 0 && WB_WrReg == src) return 1;
        return 0;
    endfunction

    function automatic bit id_reads(input logic [4:0] r);
        if (r == 0) return 0;
        return (r == ID_rs) || (ID_UseRt && r == ID_rt);
    endfunction

    function automatic bit redirect();
        return ID_Branch || ID_JumpReg;
    endfunction

    function automatic bit load_use();
        return EX_MemRd && id_reads(EX_WrReg);
    endfunction

    function automatic bit model_stall();
        if (!reset) return 0;
        if (m_extra > 0) return 1;
        if (load_use()) return 1;
        if (redirect() && EX_RegWr && !EX_MemRd && id_reads(EX_WrReg)) return 1;
        if (redirect() && MEM_MemRd && id_reads(MEM_WrReg)) return 1;
        return 0;
    endfunction

    // Compare all outputs with the model, then advance the model over the
    // coming clock edge. Returns 1 ns after that edge.
    task automatic run_cycle();
        bit st, fl;
        int fa, fb;
        bit fc, fd;
        #2;
        if (!reset) begin
            m_extra = 0; m_stalls = 0; m_flushes = 0;
        end
        st = model_stall();
        fl = reset && !st && ((ID_Branch && IDcontrol_Branch) || IDcontrol_Jump);
        fa = reset ? fwd_ex(EX_rs) : 0;
        fb = reset ? fwd_ex(EX_rt) : 0;
        fc = reset && redirect() && MEM_RegWr && !MEM_MemRd && MEM_WrReg != 0 && MEM_WrReg == ID_rs;
        fd = reset && redirect() && MEM_RegWr && !MEM_MemRd && ID_UseRt
             && MEM_WrReg != 0 && MEM_WrReg == ID_rt;
        check("fwd_a", 32'(ForwardA), 32'(fa));
        check("fwd_b", 32'(ForwardB), 32'(fb));
        check("fwd_c", 32'(ForwardC), 32'(fc));
        check("fwd_d", 32'(ForwardD), 32'(fd));
        check("pc_write", 32'(PC_Write), 32'(!st));
        check("ifid_write", 32'(IFID_Write), 32'(!st));
        check("idex_flush", 32'(IDEX_flush), 32'(st));
        check("ifid_flush", 32'(IFID_flush), 32'(fl));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
        check("in_stall_b", 32'(dbg_state), 32'(m_extra > 0));
        if (reset) begin
            if (m_extra > 0) m_extra--;
            else if (redirect() && load_use()) m_extra = 1;
            if (st) m_stalls = (m_stalls + 1) % (1 << CNT_W);
            if (fl) m_flushes = (m_flushes + 1) % (1 << CNT_W);
        end
        @(posedge clk);
        #1;
    endtask

    // Driver helpers
    task automatic clear_inputs();
        ID_rs = 0; ID_rt = 0; EX_rs = 0; EX_rt = 0;
        EX_WrReg = 0; MEM_WrReg = 0; WB_WrReg = 0;
        ID_UseRt = 0; ID_Branch = 0; ID_JumpReg = 0;
        IDcontrol_Branch = 0; IDcontrol_Jump = 0;
        EX_RegWr = 0; EX_MemRd = 0; MEM_RegWr = 0; MEM_MemRd = 0; WB_RegWr = 0;
    endtask

    task automatic lw_then_beq();
        clear_inputs();
        EX_MemRd = 1; EX_RegWr = 1; EX_WrReg = 4;
        ID_Branch = 1; ID_rs = 4; ID_rt = 5; ID_UseRt = 1; IDcontrol_Branch = 1;
    endtask

    task automatic randomize_inputs();
        ID_rs = 5'($urandom_range(0, 3));
        ID_rt = 5'($urandom_range(0, 3));
        EX_rs = 5'($urandom_range(0, 3));
        EX_rt = 5'($urandom_range(0, 3));
        EX_WrReg = 5'($urandom_range(0, 3));
        MEM_WrReg = 5'($urandom_range(0, 3));
        WB_WrReg = 5'($urandom_range(0, 3));
        ID_UseRt = 1'($urandom);
        ID_Branch = ($urandom_range(0, 2) == 0);
        ID_JumpReg = ($urandom_range(0, 5) == 0);
        IDcontrol_Branch = 1'($urandom);
        IDcontrol_Jump = ($urandom_range(0, 5) == 0);
        EX_RegWr = 1'($urandom);
        EX_MemRd = ($urandom_range(0, 2) == 0);
        MEM_RegWr = 1'($urandom);
        MEM_MemRd = ($urandom_range(0, 3) == 0);
        WB_RegWr = 1'($urandom);
    endtask

    initial begin
        clear_inputs();
        reset = 0;
        #1;
        check("rst_pc_write", 32'(PC_Write), 32'd1);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        run_cycle();
        reset = 1;
        run_cycle();

        // Forward from MEM, and MEM still wins when WB matches too.
        clear_inputs();
        MEM_RegWr = 1; MEM_WrReg = 8; EX_rs = 8;
        #1 check("dir_fwd_mem", 32'(ForwardA), 32'd2);
        WB_RegWr = 1; WB_WrReg = 8;
        #1 check("dir_fwd_mem_over_wb", 32'(ForwardA), 32'd2);
        run_cycle();

        // Load-use: one stall cycle.
        clear_inputs();
        EX_MemRd = 1; EX_RegWr = 1; EX_WrReg = 9; ID_rt = 9; ID_UseRt = 1;
        #1;
        check("dir_lu_pc_write", 32'(PC_Write), 32'd0);
        check("dir_lu_idex_flush", 32'(IDEX_flush), 32'd1);
        run_cycle();
        check("dir_lu_stall_cnt", 32'(stall_cnt), 32'd1);
        clear_inputs();
        MEM_MemRd = 1; MEM_RegWr = 1; MEM_WrReg = 9; ID_rt = 9; ID_UseRt = 1;
        #1 check("dir_lu_release", 32'(PC_Write), 32'd1);
        run_cycle();

        // Load then branch: two stalls and no flush, then the branch resolves.
        lw_then_beq();
        #1 check("dir_lb_no_flush1", 32'(IFID_flush), 32'd0);
        run_cycle();
        check("dir_lb_in_stall_b", 32'(dbg_state), 32'd1);
        check("dir_lb_no_flush2", 32'(IFID_flush), 32'd0);
        check("dir_lb_pc_write2", 32'(PC_Write), 32'd0);
        run_cycle();
        check("dir_lb_stall_cnt", 32'(stall_cnt), 32'd3);
        check("dir_lb_back_run", 32'(dbg_state), 32'd0);
        clear_inputs();
        ID_Branch = 1; ID_rs = 4; ID_rt = 5; ID_UseRt = 1; IDcontrol_Branch = 1;
        WB_RegWr = 1; WB_WrReg = 4;
        #1 check("dir_lb_flush", 32'(IFID_flush), 32'd1);
        run_cycle();

        // ALU result in MEM forwarded to a branch in ID.
        clear_inputs();
        MEM_RegWr = 1; MEM_WrReg = 3; ID_Branch = 1; ID_rs = 3; IDcontrol_Branch = 1;
        #1;
        check("dir_bne_fwd_c", 32'(ForwardC), 32'd1);
        check("dir_bne_no_stall", 32'(PC_Write), 32'd1);
        check("dir_bne_flush", 32'(IFID_flush), 32'd1);
        run_cycle();
        check("dir_bne_flush_cnt", 32'(flush_cnt), 32'd2);

        // Writes to $0 never forward or stall.
        clear_inputs();
        EX_RegWr = 1; EX_MemRd = 1; MEM_RegWr = 1; WB_RegWr = 1;
        ID_Branch = 1; ID_UseRt = 1;
        #1;
        check("dir_r0_fwd_a", 32'(ForwardA), 32'd0);
        check("dir_r0_fwd_b", 32'(ForwardB), 32'd0);
        check("dir_r0_no_stall", 32'(PC_Write), 32'd1);
        run_cycle();

        // Reset asserted in STALL_B cancels the remaining stall.
        lw_then_beq();
        run_cycle();
        check("dir_rst_pre_stall_b", 32'(dbg_state), 32'd1);
        reset = 0;
        #1;
        check("dir_rst_state", 32'(dbg_state), 32'd0);
        check("dir_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("dir_rst_flush_cnt", 32'(flush_cnt), 32'd0);
        check("dir_rst_pc_write", 32'(PC_Write), 32'd1);
        run_cycle();
        reset = 1;
        clear_inputs();
        #1 check("dir_post_rst_pc_write", 32'(PC_Write), 32'd1);
        run_cycle();

        // Random traffic, with reset asserted now and then.
        for (int i = 0; i < 500; i++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 39) != 0);
            run_cycle();
        end
        reset = 1;
        clear_inputs();
        run_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard.md
Name: pipeline_hazard

Overview:
Hazard and forwarding controller for the 5-stage MIPS pipeline. It produces the operand-forward selects for the EX stage (ForwardA/B) and for the ID-stage branch comparator (ForwardC/D). It also generates the PC/IF-ID write enables, IF/ID and ID/EX flushes, and the stall sequencing for loads and ID-resolved branches/jr.
The block sits beside the ID stage. It consumes ID's decode outputs and returns the ForwardC/ForwardD selects that ID uses to pick between MEM-stage data and register-file data.

Parameters:
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ID_rs  in  5  rs field of the instruction in ID
ID_rt  in  5  rt field of the instruction in ID
ID_UseRt  in  1  instruction in ID reads rt (R-type, beq, bne, sw)
ID_Branch  in  1  ID holds a conditional branch (opcodes 1, 4, 5, 6, 7)
ID_JumpReg  in  1  ID holds jr or jalr
IDcontrol_Branch  in  1  branch condition true (computed by ID on the forwarded operands)
IDcontrol_Jump  in  1  ID holds j, jal, jr or jalr
EX_rs  in  5  rs of the instruction in EX
EX_rt  in  5  rt of the instruction in EX
EX_WrReg  in  5  destination register of EX
EX_RegWr  in  1  EX writes a register
EX_MemRd  in  1  EX is a load
MEM_WrReg  in  5  destination register of MEM
MEM_RegWr  in  1  MEM writes a register
MEM_MemRd  in  1  MEM is a load
WB_WrReg  in  5  destination register of WB
WB_RegWr  in  1  WB writes a register
ForwardA  out  2  EX operand A select: 00 = register file, 10 = MEM ALU result, 01 = WB data
ForwardB  out  2  EX operand B select, same encoding as ForwardA
ForwardC  out  1  ID operand A takes MEM ALU result
ForwardD  out  1  ID operand B takes MEM ALU result
PC_Write  out  1  PC register enable
IFID_Write  out  1  IF/ID register enable
IFID_flush  out  1  squash the instruction being fetched
IDEX_flush  out  1  insert a bubble into ID/EX
stall_cnt  out  CNT_W  count of stall cycles
flush_cnt  out  CNT_W  count of IF/ID flushes

Behaviour:
- Register 0 never matches in any comparison below.
- Forwarding (combinational):
  - ForwardA = 10 if MEM_RegWr and MEM_WrReg == EX_rs.
  - Otherwise ForwardA = 01 if WB_RegWr and WB_WrReg == EX_rs.
  - Otherwise ForwardA = 00.
  - ForwardB: same rules on EX_rt. MEM has priority over WB.
  - ForwardC = (ID_Branch | ID_JumpReg) & MEM_RegWr & ~MEM_MemRd & MEM_WrReg == ID_rs.
  - ForwardD: same as ForwardC on ID_rt, and additionally requires ID_UseRt.
  - WB-to-ID data is covered by the register file's write-before-read; it is not forwarded here.
- Hazard terms, where depA = match on ID_rs and depB = ID_UseRt & match on ID_rt:
  - hzLU = EX_MemRd & EX_WrReg depends-on (depA | depB).
  - hzBrEX = (ID_Branch | ID_JumpReg) & EX_RegWr & ~EX_MemRd & EX dependence.
  - hzBrLdEX = (ID_Branch | ID_JumpReg) & hzLU.
  - hzBrLdMEM = (ID_Branch | ID_JumpReg) & MEM_MemRd & MEM dependence.
- FSM, 2 states: RUN, STALL_B.
  - RUN:
    - If hzBrLdEX: stall, and next state is STALL_B.
    - Else if hzLU, hzBrEX or hzBrLdMEM: stall, and stay in RUN (the condition is re-evaluated next cycle).
    - Else: no stall.
  - STALL_B: stall unconditionally, then go to RUN. This gives the fixed 2-cycle load-to-branch penalty.
- Stall cycle outputs: PC_Write = 0, IFID_Write = 0, IDEX_flush = 1, IFID_flush = 0.
- Non-stall cycle outputs: PC_Write = 1, IFID_Write = 1, IDEX_flush = 0, IFID_flush = (ID_Branch & IDcontrol_Branch) | IDcontrol_Jump.
- Stall has priority over flush. A taken branch is never flushed while its operands are stale.
- Counters:
  - stall_cnt increments by 1 on every stall cycle.
  - flush_cnt increments on every cycle with IFID_flush = 1.
  - Both wrap from all-ones to 0.
- Reset (reset = 0, asynchronous):
  - state = RUN, stall_cnt = 0, flush_cnt = 0.
  - Outputs during reset: PC_Write = 1, IFID_Write = 1, IFID_flush = 0, IDEX_flush = 0, ForwardA = ForwardB = 00, ForwardC = ForwardD = 0.
  - All hazard logic is gated off while reset is asserted.
  - Reset asserted during STALL_B aborts the remaining stall.
- Outputs are combinational from the inputs and state; the only registers are the FSM state and the counters.

Test Plan:
- add $8 followed by sub using $8 in EX (MEM_WrReg = 8, EX_rs = 8, MEM_RegWr = 1) -> ForwardA = 10. Also set WB_WrReg = 8 -> ForwardA stays 10.
- lw $9 in EX (EX_MemRd = 1, EX_WrReg = 9), add in ID with ID_rt = 9, ID_UseRt = 1 -> one cycle with PC_Write = 0 and IDEX_flush = 1, stall_cnt 0 -> 1, then no stall.
- lw $4 in EX, beq $4,$5 in ID -> 2 stall cycles (RUN -> STALL_B -> RUN), stall_cnt = 2, no IFID_flush during the stalls.
- addi $3 in MEM (MEM_RegWr = 1, MEM_MemRd = 0, MEM_WrReg = 3), bne $3 in ID -> ForwardC = 1, no stall. With IDcontrol_Branch = 1 -> IFID_flush = 1 and flush_cnt = 1.
- Writes to $0 in EX/MEM/WB while ID/EX operands are 0 -> all forwards 0, no stall.
- Assert reset low while in STALL_B -> state = RUN and both counters = 0 immediately. After release with no hazards -> PC_Write = 1.
